// File: rtl/output_port_allocator.sv
// Per-output-direction allocator: round-robin port ownership (VC allocation),
// owner-only switch grants gated by downstream credits, and the registered output flit mux.
module output_port_allocator #(
  parameter int unsigned NUM_IN     = 5,
  parameter int unsigned FLIT_WIDTH = 12,
  parameter int unsigned BUFF_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_IN-1:0]              vc_arb_req,
  output logic [NUM_IN-1:0]              vc_arb_gnt,
  input  logic [NUM_IN-1:0]              sw_arb_req,
  output logic [NUM_IN-1:0]              sw_arb_gnt,
  input  logic [NUM_IN-1:0]              dec_buff_count,
  input  logic [NUM_IN*FLIT_WIDTH-1:0]   flit_in,
  output logic                           usage,
  output logic [CNT_WIDTH-1:0]           buff_count,
  input  logic                           credit_in,
  output logic [FLIT_WIDTH-1:0]          flit_out,
  output logic                           flit_valid
);

  localparam int unsigned IDX_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [1:0]  FLIT_TAIL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_XFER   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  usage_q, usage_d;
  logic [CNT_WIDTH-1:0]  buff_count_q, buff_count_d;
  logic [NUM_IN-1:0]     vc_gnt_q, vc_gnt_d;
  logic [NUM_IN-1:0]     sw_gnt_q, sw_gnt_d;
  logic [FLIT_WIDTH-1:0] flit_out_q, flit_out_d;
  logic                  flit_valid_q, flit_valid_d;

  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand_idx;
  int unsigned           cand;
  logic [FLIT_WIDTH-1:0] owner_flit;
  logic                  xfer_fire;
  logic                  credit_room;

  // Round-robin search over requesters, starting at rr_ptr_q
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_IN;
      cand_idx = IDX_W'(cand);
      if (!win_found && vc_arb_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign owner_flit  = flit_in[32'(owner_q)*FLIT_WIDTH +: FLIT_WIDTH];
  assign xfer_fire   = (state_q == ST_XFER) && dec_buff_count[owner_q];
  assign credit_room = (buff_count_q < CNT_WIDTH'(BUFF_DEPTH));

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    usage_d      = usage_q;
    buff_count_d = buff_count_q;
    vc_gnt_d     = '0;
    sw_gnt_d     = '0;
    flit_out_d   = flit_out_q;
    flit_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          vc_gnt_d = NUM_IN'(1) << win_idx;
          usage_d  = 1'b1;
          owner_d  = win_idx;
          rr_ptr_d = (32'(win_idx) == NUM_IN - 1) ? '0 : win_idx + IDX_W'(1);
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (sw_arb_req[owner_q] && (buff_count_q != '0)) begin
          sw_gnt_d = NUM_IN'(1) << owner_q;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (xfer_fire) begin
          flit_out_d   = owner_flit;
          flit_valid_d = 1'b1;
          if (owner_flit[1:0] == FLIT_TAIL) begin
            usage_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A returned credit and a transfer in the same cycle cancel out
    if (xfer_fire && !credit_in) begin
      buff_count_d = buff_count_q - CNT_WIDTH'(1);
    end else if (credit_in && !xfer_fire && credit_room) begin
      buff_count_d = buff_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      usage_q      <= 1'b0;
      buff_count_q <= CNT_WIDTH'(BUFF_DEPTH);
      vc_gnt_q     <= '0;
      sw_gnt_q     <= '0;
      flit_out_q   <= '0;
      flit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      usage_q      <= usage_d;
      buff_count_q <= buff_count_d;
      vc_gnt_q     <= vc_gnt_d;
      sw_gnt_q     <= sw_gnt_d;
      flit_out_q   <= flit_out_d;
      flit_valid_q <= flit_valid_d;
    end
  end

  assign vc_arb_gnt = vc_gnt_q;
  assign sw_arb_gnt = sw_gnt_q;
  assign usage      = usage_q;
  assign buff_count = buff_count_q;
  assign flit_out   = flit_out_q;
  assign flit_valid = flit_valid_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed and randomized checks of output_port_allocator against a packet-level
// reference model (phase of the owning packet, credit count, round-robin distance).
module tb_output_port_allocator;

  localparam int N  = 5;
  localparam int FW = 12;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [N-1:0]  vc_arb_req, vc_arb_gnt, sw_arb_req, sw_arb_gnt, dec_buff_count;
  logic [N*FW-1:0] flit_in;
  logic          usage, credit_in, flit_valid;
  logic [7:0]    buff_count;
  logic [FW-1:0] flit_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 = port free, 1 = owned awaiting sw grant, 2 = granted awaiting flit
  int          m_phase, m_owner, m_rr, m_cnt;
  logic [FW-1:0] m_fo;

  output_port_allocator dut (
    .Clk(Clk), .Rst(Rst),
    .vc_arb_req(vc_arb_req), .vc_arb_gnt(vc_arb_gnt),
    .sw_arb_req(sw_arb_req), .sw_arb_gnt(sw_arb_gnt),
    .dec_buff_count(dec_buff_count), .flit_in(flit_in),
    .usage(usage), .buff_count(buff_count), .credit_in(credit_in),
    .flit_out(flit_out), .flit_valid(flit_valid)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_cnt = 8; m_fo = '0;
  endtask

  function automatic logic [N*FW-1:0] one_flit(input int port, input logic [FW-1:0] f);
    logic [N*FW-1:0] v;
    v = '0;
    v[port*FW +: FW] = f;
    return v;
  endfunction

  // Apply one cycle of inputs (from a negedge), predict, and compare after the edge
  task automatic cycle(input logic [N-1:0] vreq, input logic [N-1:0] sreq,
                       input logic [N-1:0] dec, input logic [N*FW-1:0] fin,
                       input logic cin);
    logic [N-1:0]  e_vc, e_sw;
    logic          e_fv, xfer;
    logic [FW-1:0] sl;
    int n_phase, n_owner, n_rr, best, bestd, d;
    vc_arb_req = vreq; sw_arb_req = sreq; dec_buff_count = dec;
    flit_in = fin; credit_in = cin;

    e_vc = '0; e_sw = '0; e_fv = 1'b0;
    n_phase = m_phase; n_owner = m_owner; n_rr = m_rr;
    sl   = fin[m_owner*FW +: FW];
    xfer = (m_phase == 2) && dec[m_owner];
    if (m_phase == 0 && vreq != '0) begin
      best = 0; bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_rr + N) % N;
        if (vreq[i] && d < bestd) begin best = i; bestd = d; end
      end
      e_vc[best] = 1'b1;
      n_owner = best; n_rr = (best + 1) % N; n_phase = 1;
    end else if (m_phase == 1 && sreq[m_owner] && m_cnt > 0) begin
      e_sw[m_owner] = 1'b1;
      n_phase = 2;
    end else if (xfer) begin
      e_fv = 1'b1;
      m_fo = sl;
      n_phase = (sl[1:0] == 2'd2) ? 0 : 1;
    end

    @(posedge Clk);
    #1;
    if (xfer && !cin) m_cnt = m_cnt - 1;
    else if (cin && !xfer && m_cnt < 8) m_cnt = m_cnt + 1;
    m_phase = n_phase; m_owner = n_owner; m_rr = n_rr;

    check("vc_gnt", vc_arb_gnt, e_vc);
    check("sw_gnt", sw_arb_gnt, e_sw);
    check("usage", usage, (m_phase != 0));
    check("buff_count", buff_count, m_cnt);
    check("flit_valid", flit_valid, e_fv);
    check("flit_out", flit_out, m_fo);
    @(negedge Clk);
  endtask

  logic [FW-1:0] pkt [3];

  initial begin
    logic [N-1:0] v, s, dd;
    logic [N*FW-1:0] f;
    pkt[0] = 12'h0C4; pkt[1] = 12'h0A1; pkt[2] = 12'h0B2;
    vc_arb_req = '0; sw_arb_req = '0; dec_buff_count = '0; flit_in = '0; credit_in = 1'b0;
    Rst = 1'b1;
    model_reset();
    repeat (2) @(negedge Clk);
    check("rst_usage", usage, 0);
    check("rst_buff_count", buff_count, 8);
    check("rst_vc_gnt", vc_arb_gnt, 0);
    check("rst_sw_gnt", sw_arb_gnt, 0);
    check("rst_flit_valid", flit_valid, 0);
    check("rst_flit_out", flit_out, 0);
    Rst = 1'b0;

    // Round-robin from 0 picks port 1, then a three-flit packet
    cycle(5'b00110, '0, '0, '0, 1'b0);
    check("rr_first", vc_arb_gnt, 5'b00010);
    for (int i = 0; i < 3; i++) begin
      cycle('0, 5'b00010, '0, '0, 1'b0);
      check("pkt_sw_gnt", sw_arb_gnt, 5'b00010);
      cycle('0, '0, 5'b00010, one_flit(1, pkt[i]), 1'b0);
      check("pkt_flit", flit_out, pkt[i]);
    end
    check("pkt_buff_count", buff_count, 5);
    check("pkt_usage", usage, 0);
    cycle(5'b00110, '0, '0, '0, 1'b0);
    check("rr_second", vc_arb_gnt, 5'b00100);

    // Drain credits with owner 2, then stall on zero credits
    for (int i = 0; i < 5; i++) begin
      cycle('0, 5'b00100, '0, '0, 1'b0);
      cycle('0, '0, 5'b00100, one_flit(2, 12'h001), 1'b0);
    end
    check("drain_count", buff_count, 0);
    repeat (3) cycle('0, 5'b00100, '0, '0, 1'b0);
    check("stall_sw_gnt", sw_arb_gnt, 0);
    cycle('0, 5'b00100, '0, '0, 1'b1);
    check("credit_to_one", buff_count, 1);
    cycle('0, 5'b00100, '0, '0, 1'b0);
    check("grant_after_credit", sw_arb_gnt, 5'b00100);
    repeat (2) cycle('0, '0, '0, '0, 1'b1);
    cycle('0, '0, 5'b00100, one_flit(2, 12'h011), 1'b1);
    check("credit_and_xfer", buff_count, 3);
    repeat (6) cycle('0, '0, '0, '0, 1'b1);
    check("credit_saturate", buff_count, 8);

    // Reset asserted while owner 2 is in XFER
    cycle('0, 5'b00100, '0, '0, 1'b0);
    Rst = 1'b1;
    #2;
    check("async_rst_usage", usage, 0);
    check("async_rst_sw_gnt", sw_arb_gnt, 0);
    check("async_rst_count", buff_count, 8);
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    cycle('0, '0, 5'b00100, one_flit(2, 12'h0C2), 1'b0);
    check("post_rst_dec_ignored", flit_valid, 0);
    cycle(5'b00110, '0, '0, '0, 1'b0);
    check("post_rst_rr", vc_arb_gnt, 5'b00010);

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      v  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      s  = N'($urandom);
      dd = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 9) < 6) s[m_owner] = 1'b1;
      if ($urandom_range(0, 9) < 5) dd[m_owner] = 1'b1;
      f = {$urandom, $urandom};
      for (int p = 0; p < N; p++) f[p*FW +: 2] = 2'($urandom_range(0, 3));
      cycle(v, s, dd, f, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
